keypad_debounce_decoder: RTL and testbench
==========================================

KEYPAD_DEBOUNCE_DECODER -- requirements
Module: keypad_debounce_decoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20, is the number of consecutive button_on-high (press) or button_on-low (release) cycles needed to accept an edge; legal range 2..2^20.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 keypad_val  input  8  scanner snapshot {R0,R1,R2,R3,C0,C1,C2,C3}, row bits [7:4], column bits [3:0].
REQ-005 en  input  1  scanner decode strobe; keypad_val is valid in any cycle where en=1.
REQ-006 button_on  input  1  OR of the column inputs; high while any key is pressed.
REQ-007 digit_new  output  4  hex code of the most recently accepted key.
REQ-008 digit_old  output  4  hex code of the key accepted before digit_new.
REQ-009 key_valid  output  1  one-cycle pulse, high in the cycle after digit_new/digit_old update.
REQ-010 key_error  output  1  one-cycle pulse flagging a rejected multi-key or malformed snapshot.

Function
REQ-011 Key map, row/column to code: R0: C0=1, C1=2, C2=3, C3=A; R1: 4, 5, 6, B; R2: 7, 8, 9, C; R3: E, 0, F, D.
REQ-012 A snapshot is legal only if exactly one row bit and exactly one column bit are set; any other snapshot is illegal.
REQ-013 The FSM has five states: IDLE, DEBOUNCE, COMMIT, HELD, RELEASE.
REQ-014 IDLE, en=1, legal snapshot: the decoded code goes into a capture register, the counter clears, and the FSM moves to DEBOUNCE.
REQ-015 IDLE, en=1, illegal snapshot: key_error pulses for 1 cycle next cycle; the FSM stays in IDLE; digits are unchanged.
REQ-016 DEBOUNCE: counter increments each cycle button_on=1; if button_on=0 the FSM returns to IDLE with no commit (glitch reject).
REQ-017 DEBOUNCE: when counter==DEBOUNCE_CYCLES-1 and button_on=1, the FSM moves to COMMIT.
REQ-018 COMMIT, single cycle: digit_old<=digit_new, digit_new<=captured code, key_valid<=1 for exactly 1 cycle, then the FSM moves to HELD.
REQ-019 Latency: en in IDLE at cycle 0 with button_on held high produces key_valid high in cycle DEBOUNCE_CYCLES+2.
REQ-020 HELD: the FSM stays while button_on=1 and never re-commits (no auto-repeat); button_on=0 clears the counter and moves to RELEASE.
REQ-021 RELEASE: counter increments each cycle button_on=0; button_on=1 returns the FSM to HELD (bounce); counter==DEBOUNCE_CYCLES-1 moves it to IDLE.
REQ-022 en is ignored in every state except IDLE, including a simultaneous en and FSM transition.
REQ-023 The counter is $clog2(DEBOUNCE_CYCLES+1) bits wide, is unsigned, saturates and never wraps, and clears on every state entry.
REQ-024 key_valid and key_error are never high in the same cycle.
REQ-025 All outputs are registered; there are no combinational paths from inputs to outputs.

Reset
REQ-026 While reset=0: state=IDLE, counter=0, capture=0, digit_new=0, digit_old=0, key_valid=0, key_error=0, applied immediately and independent of clk.
REQ-027 A reset asserted mid-DEBOUNCE/COMMIT/HELD aborts the operation; no key_valid pulse follows deassertion.
REQ-028 After deassertion the block is in IDLE and accepts en on the first rising clk edge.

Structure
REQ-029 Package keypad_pkg holds the FSM state enum, the key-code constants (4-bit), and DEBOUNCE_DEFAULT=20.
REQ-030 One sub-module, keypad_code_lut, combinational: keypad_val in, 4-bit code plus legal flag out, implementing REQ-011/REQ-012.

Verification
REQ-031 DEBOUNCE_CYCLES=20; keypad_val=8'b0100_0100, en for 1 cycle, button_on high 40 cycles -> exactly one key_valid, in cycle 22; digit_new=5, digit_old=0.
REQ-032 keypad_val=8'b1000_1000 then 8'b1000_0001 (keys 1 then A), each pressed 40 cycles and released 40 cycles -> digit_old=1, digit_new=A, two key_valid pulses total.
REQ-033 Legal snapshot with button_on high only 5 cycles -> no key_valid, digits unchanged, FSM back in IDLE.
REQ-034 keypad_val=8'b1000_1100 with en -> key_error one pulse, no key_valid, digits unchanged.
REQ-035 Key 9 held, then 3 release bounces shorter than 20 cycles, then clean release -> exactly one key_valid; the next en is accepted only after 20 low cycles.
REQ-036 reset=0 at cycle 10 of DEBOUNCE -> all outputs 0 asynchronously; no key_valid after release of reset.

Source files
------------

// File: rtl/keypad_debounce_decoder_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad debounce/decoder block:
//   - keypadState_t : FSM state encoding
//   - KEY_*         : 4-bit codes reported for each key
//   - DEBOUNCE_DEFAULT : default number of stable cycles to accept an edge
//   - isOneHot / keyCode : helpers used by the row/column lookup
// ---------------------------------------------------------------------------
package keypad_pkg;

    localparam int unsigned DEBOUNCE_DEFAULT = 20;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_COMMIT   = 3'd2,
        ST_HELD     = 3'd3,
        ST_RELEASE  = 3'd4
    } keypadState_t;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    // True when exactly one bit of the nibble is set.
    function automatic logic isOneHot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    // Row index 0..3 (R0..R3) and column index 0..3 (C0..C3) to key code.
    function automatic logic [3:0] keyCode(input logic [1:0] rowIdx,
                                           input logic [1:0] colIdx);
        logic [3:0] code;
        case ({rowIdx, colIdx})
            4'b00_00: code = KEY_1;
            4'b00_01: code = KEY_2;
            4'b00_10: code = KEY_3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = KEY_4;
            4'b01_01: code = KEY_5;
            4'b01_10: code = KEY_6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = KEY_7;
            4'b10_01: code = KEY_8;
            4'b10_10: code = KEY_9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_E;
            4'b11_01: code = KEY_0;
            4'b11_10: code = KEY_F;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce_decoder_code_lut.sv
// ---------------------------------------------------------------------------
// keypad_code_lut
// Purely combinational decode of one scanner snapshot.
// Ports:
//   i_keypad_val [7:0] : {R0,R1,R2,R3,C0,C1,C2,C3} snapshot
//   o_code       [3:0] : key code (meaningful only when o_legal=1)
//   o_legal            : exactly one row bit and one column bit are set
// ---------------------------------------------------------------------------
module keypad_code_lut
    import keypad_pkg::*;
(
    input  logic [7:0] i_keypad_val,
    output logic [3:0] o_code,
    output logic       o_legal
);

    logic [3:0] w_rows;
    logic [3:0] w_cols;
    logic [1:0] w_rowIdx;
    logic [1:0] w_colIdx;

    assign w_rows = i_keypad_val[7:4];
    assign w_cols = i_keypad_val[3:0];

    // R0 and C0 sit in the most significant bit of their nibble, so the
    // index counts down from the top bit.
    always_comb begin
        w_rowIdx = 2'd0;
        case (w_rows)
            4'b1000: w_rowIdx = 2'd0;
            4'b0100: w_rowIdx = 2'd1;
            4'b0010: w_rowIdx = 2'd2;
            4'b0001: w_rowIdx = 2'd3;
            default: w_rowIdx = 2'd0;
        endcase
    end

    always_comb begin
        w_colIdx = 2'd0;
        case (w_cols)
            4'b1000: w_colIdx = 2'd0;
            4'b0100: w_colIdx = 2'd1;
            4'b0010: w_colIdx = 2'd2;
            4'b0001: w_colIdx = 2'd3;
            default: w_colIdx = 2'd0;
        endcase
    end

    assign o_legal = isOneHot(w_rows) && isOneHot(w_cols);
    assign o_code  = keyCode(w_rowIdx, w_colIdx);

endmodule

// File: rtl/keypad_debounce_decoder.sv
// ---------------------------------------------------------------------------
// keypad_debounce_decoder
// Accepts a decoded key from the scanner, debounces press and release on
// button_on, and reports the last two accepted keys.
// Ports:
//   clk        : clock, all state on rising edge
//   reset      : asynchronous active-low reset
//   keypad_val : scanner snapshot {R0..R3,C0..C3}, valid when en=1
//   en         : scanner decode strobe, only honoured in IDLE
//   button_on  : high while any key is pressed
//   digit_new  : most recently accepted key code
//   digit_old  : key code accepted before digit_new
//   key_valid  : one-cycle pulse after a key is committed
//   key_error  : one-cycle pulse after a rejected (illegal) snapshot
// ---------------------------------------------------------------------------
module keypad_debounce_decoder
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keypad_val,
    input  logic       en,
    input  logic       button_on,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       key_valid,
    output logic       key_error
);

    localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    keypadState_t     r_state;
    keypadState_t     w_nextState;
    logic [CNT_W-1:0] r_count;
    logic [3:0]       r_capture;
    logic [3:0]       r_digitNew;
    logic [3:0]       r_digitOld;
    logic             r_keyValid;
    logic             r_keyError;

    logic [3:0]       w_code;
    logic             w_legal;
    logic             w_countDone;
    logic             w_capture;
    logic             w_reject;
    logic             w_commit;
    logic             w_countEn;

    keypad_code_lut u_lut (
        .i_keypad_val (keypad_val),
        .o_code       (w_code),
        .o_legal      (w_legal)
    );

    assign w_countDone = (r_count == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A drop of button_on during DEBOUNCE is treated as a
    // glitch; a rise during RELEASE is treated as contact bounce.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en && w_legal) begin
                    w_nextState = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (!button_on) begin
                    w_nextState = ST_IDLE;
                end else if (w_countDone) begin
                    w_nextState = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_nextState = ST_HELD;
            end
            ST_HELD: begin
                if (!button_on) begin
                    w_nextState = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (button_on) begin
                    w_nextState = ST_HELD;
                end else if (w_countDone) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Output/control decode from the current state.
    always_comb begin
        w_capture = 1'b0;
        w_reject  = 1'b0;
        w_commit  = 1'b0;
        w_countEn = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_capture = en && w_legal;
                w_reject  = en && !w_legal;
            end
            ST_DEBOUNCE: begin
                w_countEn = button_on;
            end
            ST_COMMIT: begin
                w_commit = 1'b1;
            end
            ST_RELEASE: begin
                w_countEn = !button_on;
            end
            default: begin
                w_countEn = 1'b0;
            end
        endcase
    end

    // Datapath registers. The counter restarts on every state change so each
    // state measures its own run of stable cycles; it saturates rather than
    // wrapping. Both pulses are registered so outputs never see inputs
    // combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_capture  <= 4'h0;
            r_digitNew <= 4'h0;
            r_digitOld <= 4'h0;
            r_keyValid <= 1'b0;
            r_keyError <= 1'b0;
        end else begin
            if (w_nextState != r_state) begin
                r_count <= '0;
            end else if (w_countEn && (r_count != CNT_MAX)) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_capture) begin
                r_capture <= w_code;
            end
            if (w_commit) begin
                r_digitOld <= r_digitNew;
                r_digitNew <= r_capture;
            end
            r_keyValid <= w_commit;
            r_keyError <= w_reject;
        end
    end

    assign digit_new = r_digitNew;
    assign digit_old = r_digitOld;
    assign key_valid = r_keyValid;
    assign key_error = r_keyError;

endmodule

// File: tb/tb_keypad_debounce_decoder.sv
// ---------------------------------------------------------------------------
// tb_keypad_debounce_decoder
// Scoreboard bench: stimulus pushes the expected pulse (kind, digits, cycle)
// into a queue; a negedge monitor pops and compares whenever the DUT
// raises key_valid or key_error.
// ---------------------------------------------------------------------------
module tb_keypad_debounce_decoder;

    localparam int DEB = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] keypad_val = 8'h00;
    logic       en = 1'b0;
    logic       button_on = 1'b0;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       key_valid;
    logic       key_error;

    int checks = 0;
    int failures = 0;
    int cycleCnt = 0;

    logic [3:0] modelNew = 4'h0;
    logic [3:0] modelOld = 4'h0;

    typedef struct {
        bit         isError;
        logic [3:0] dNew;
        logic [3:0] dOld;
        int         cycle;
    } expect_t;

    expect_t sbQueue[$];

    keypad_debounce_decoder #(
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .keypad_val (keypad_val),
        .en         (en),
        .button_on  (button_on),
        .digit_new  (digit_new),
        .digit_old  (digit_old),
        .key_valid  (key_valid),
        .key_error  (key_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)",
                     name, actual, expected, cycleCnt);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushExpect(input bit isErr, input logic [3:0] dNew,
                              input logic [3:0] dOld, input int cyc);
        expect_t e;
        e.isError = isErr;
        e.dNew    = dNew;
        e.dOld    = dOld;
        e.cycle   = cyc;
        sbQueue.push_back(e);
    endtask

    // One full press: en for one cycle, button high for 'hold' cycles
    // (counting the en cycle), then low for 'rel' cycles.
    task automatic applyStimulus(input logic [7:0] val, input logic [3:0] expCode,
                                 input int hold, input int rel,
                                 input bit expectCommit);
        int start;
        start = cycleCnt;
        keypad_val = val;
        en = 1'b1;
        button_on = 1'b1;
        if (expectCommit) begin
            pushExpect(1'b0, expCode, modelNew, start + DEB + 2);
            modelOld = modelNew;
            modelNew = expCode;
        end
        tick(1);
        en = 1'b0;
        keypad_val = 8'h00;
        tick(hold - 1);
        button_on = 1'b0;
        tick(rel);
    endtask

    task automatic applyIllegal(input logic [7:0] val);
        int start;
        start = cycleCnt;
        keypad_val = val;
        en = 1'b1;
        pushExpect(1'b1, modelNew, modelOld, start + 1);
        tick(1);
        en = 1'b0;
        keypad_val = 8'h00;
        tick(3);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        expect_t e;
        if (reset && (key_valid || key_error)) begin
            checkOutput("valid_error_exclusive", 32'(key_valid && key_error), 32'd0);
            if (sbQueue.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pulse: valid=%0b error=%0b cycle=%0d, required no pulse",
                         key_valid, key_error, cycleCnt);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("pulse_is_error", 32'(key_error), 32'(e.isError));
                checkOutput("digit_new", 32'(digit_new), 32'(e.dNew));
                checkOutput("digit_old", 32'(digit_old), 32'(e.dOld));
                if (e.cycle >= 0) begin
                    checkOutput("pulse_cycle", 32'(cycleCnt), 32'(e.cycle));
                end
            end
        end
    end

    initial begin
        int waitCnt;
        int start;

        // Reset values.
        #3;
        checkOutput("rst_digit_new", 32'(digit_new), 32'd0);
        checkOutput("rst_digit_old", 32'(digit_old), 32'd0);
        checkOutput("rst_key_valid", 32'(key_valid), 32'd0);
        checkOutput("rst_key_error", 32'(key_error), 32'd0);
        tick(3);
        reset = 1'b1;

        // Key 5 straight after reset release; pulse 22 cycles after en.
        applyStimulus(8'b0100_0100, 4'h5, 40, 40, 1'b1);
        // Keys 1 then A.
        applyStimulus(8'b1000_1000, 4'h1, 40, 40, 1'b1);
        applyStimulus(8'b1000_0001, 4'hA, 40, 40, 1'b1);
        // Short press of key 8 is a glitch.
        applyStimulus(8'b0010_0100, 4'h8, 5, 10, 1'b0);
        // Illegal snapshots.
        applyIllegal(8'b1000_1100);
        applyIllegal(8'b0000_0000);
        applyIllegal(8'b1100_1000);

        // Key 9 with illegal strobes while debouncing, held and releasing;
        // none of them may be accepted.
        start = cycleCnt;
        keypad_val = 8'b0010_0010;
        en = 1'b1;
        button_on = 1'b1;
        pushExpect(1'b0, 4'h9, modelNew, start + DEB + 2);
        modelOld = modelNew;
        modelNew = 4'h9;
        tick(1);
        en = 1'b0;
        keypad_val = 8'h00;
        tick(4);
        keypad_val = 8'hC0;
        en = 1'b1;
        tick(1);
        en = 1'b0;
        keypad_val = 8'h00;
        tick(24);
        keypad_val = 8'hC0;
        en = 1'b1;
        tick(1);
        en = 1'b0;
        keypad_val = 8'h00;
        repeat (3) begin
            button_on = 1'b0;
            tick(5);
            button_on = 1'b1;
            tick(3);
        end
        button_on = 1'b0;
        tick(10);
        keypad_val = 8'hC0;
        en = 1'b1;
        tick(1);
        en = 1'b0;
        keypad_val = 8'h00;
        tick(30);
        applyStimulus(8'b0010_0100, 4'h8, 40, 40, 1'b1);

        // Reset in the middle of debouncing key 6.
        keypad_val = 8'b0100_0010;
        en = 1'b1;
        button_on = 1'b1;
        tick(1);
        en = 1'b0;
        keypad_val = 8'h00;
        tick(9);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_rst_digit_new", 32'(digit_new), 32'd0);
        checkOutput("async_rst_digit_old", 32'(digit_old), 32'd0);
        checkOutput("async_rst_key_valid", 32'(key_valid), 32'd0);
        checkOutput("async_rst_key_error", 32'(key_error), 32'd0);
        tick(2);
        reset = 1'b1;
        modelNew = 4'h0;
        modelOld = 4'h0;
        tick(40);
        button_on = 1'b0;
        tick(5);
        checkOutput("post_rst_digit_new", 32'(digit_new), 32'd0);

        // Row 3 keys.
        applyStimulus(8'b0001_0001, 4'hD, 40, 40, 1'b1);
        applyStimulus(8'b0001_0010, 4'hF, 40, 40, 1'b1);

        // Every expected pulse must have been seen.
        waitCnt = 0;
        while (sbQueue.size() != 0 && waitCnt < 100) begin
            tick(1);
            waitCnt++;
        end
        checkOutput("scoreboard_drained", 32'(sbQueue.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
